clk_10k_monitor: RTL and testbench

- Receive-side counterpart to the 10 kHz sequencing clock generator.
- Samples an externally supplied slow clock (nominally 10 kHz) in the clk_sys domain and measures its period in clk_sys cycles.
- Flags out-of-range periods and loss of clock, and asserts a lock indication once the clock is stable.
- Downstream pulse-sequencing logic is gated on clk_locked.

---
 rtl/clk_10k_monitor.sv | 136 +++++++++++++
 tb/tb_clk_10k_monitor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/clk_10k_monitor.sv
// rtl/clk_10k_monitor.sv - period, range, loss-of-clock and lock monitor for the 10 kHz sequencing clock
module clk_10k_monitor #(
    parameter int CNT_W      = 16,
    parameter int NOM_PERIOD = 5000,
    parameter int TOL        = 50,
    parameter int TIMEOUT    = 10000,
    parameter int LOCK_CNT   = 4
) (
    input  logic             clk_sys,
    input  logic             rst,
    input  logic             en,
    input  logic             clk_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             period_ok,
    output logic             clk_lost,
    output logic             clk_locked
);
    localparam int                LOCK_W   = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0]  MIN_P    = CNT_W'(NOM_PERIOD - TOL);
    localparam logic [CNT_W-1:0]  MAX_P    = CNT_W'(NOM_PERIOD + TOL);
    localparam logic [CNT_W-1:0]  TMO      = CNT_W'(TIMEOUT);
    localparam logic [LOCK_W-1:0] LOCK_MAX = LOCK_W'(LOCK_CNT);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_EDGE = 2'd1,
        MEASURE   = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              s1;
    logic              s2;
    logic              s3;
    logic              rise;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [CNT_W-1:0]  cnt_inc;
    logic [LOCK_W-1:0] lock_cnt;
    logic [LOCK_W-1:0] lock_cnt_nxt;
    logic [LOCK_W-1:0] lock_inc;
    logic [CNT_W-1:0]  period_out_nxt;
    logic              period_valid_nxt;
    logic              period_ok_nxt;
    logic              clk_lost_nxt;
    logic              clk_locked_nxt;
    logic              in_range;
    logic              timed_out;

    assign rise      = s2 & ~s3;
    assign cnt_inc   = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    assign lock_inc  = (lock_cnt == LOCK_MAX) ? lock_cnt : lock_cnt + LOCK_W'(1);
    assign in_range  = (cnt >= MIN_P) && (cnt <= MAX_P);
    assign timed_out = (cnt == TMO);

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            s1           <= 1'b0;
            s2           <= 1'b0;
            s3           <= 1'b0;
            state        <= IDLE;
            cnt          <= '0;
            lock_cnt     <= '0;
            period_out   <= '0;
            period_valid <= 1'b0;
            period_ok    <= 1'b0;
            clk_lost     <= 1'b0;
            clk_locked   <= 1'b0;
        end else begin
            s1           <= clk_in;
            s2           <= s1;
            s3           <= s2;
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            lock_cnt     <= lock_cnt_nxt;
            period_out   <= period_out_nxt;
            period_valid <= period_valid_nxt;
            period_ok    <= period_ok_nxt;
            clk_lost     <= clk_lost_nxt;
            clk_locked   <= clk_locked_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:      state_nxt = WAIT_EDGE;
                WAIT_EDGE: if (rise) state_nxt = MEASURE;
                MEASURE:   if (!rise && timed_out) state_nxt = WAIT_EDGE;
                default:   state_nxt = IDLE;
            endcase
        end
    end

    // A rise always takes priority over the timeout in the same cycle.
    always_comb begin
        cnt_nxt          = cnt_inc;
        lock_cnt_nxt     = lock_cnt;
        period_out_nxt   = period_out;
        period_valid_nxt = 1'b0;
        period_ok_nxt    = period_ok;
        clk_lost_nxt     = clk_lost;
        clk_locked_nxt   = clk_locked;
        if (!en || state == IDLE) begin
            cnt_nxt        = '0;
            lock_cnt_nxt   = '0;
            clk_lost_nxt   = 1'b0;
            clk_locked_nxt = 1'b0;
        end else if (rise) begin
            cnt_nxt = CNT_W'(1);
            if (state == WAIT_EDGE) begin
                clk_lost_nxt = 1'b0;
            end else begin
                period_out_nxt   = cnt;
                period_valid_nxt = 1'b1;
                period_ok_nxt    = in_range;
                if (in_range) begin
                    lock_cnt_nxt   = lock_inc;
                    clk_locked_nxt = (lock_inc == LOCK_MAX);
                end else begin
                    lock_cnt_nxt   = '0;
                    clk_locked_nxt = 1'b0;
                end
            end
        end else if (timed_out) begin
            cnt_nxt        = '0;
            lock_cnt_nxt   = '0;
            clk_lost_nxt   = 1'b1;
            clk_locked_nxt = 1'b0;
        end
    end
endmodule

// File: tb/tb_clk_10k_monitor.sv
// tb/tb_clk_10k_monitor.sv - self-checking bench for clk_10k_monitor
`timescale 1ns/1ps
module tb_clk_10k_monitor;
    localparam int CNT_W   = 16;
    localparam int NOM     = 5000;
    localparam int TOL     = 50;
    localparam int TIMEOUT = 10000;
    localparam int LOCK    = 4;

    logic             clk_sys = 1'b0;
    logic             rst     = 1'b1;
    logic             en      = 1'b0;
    logic             clk_in  = 1'b0;
    logic [CNT_W-1:0] period_out;
    logic             period_valid;
    logic             period_ok;
    logic             clk_lost;
    logic             clk_locked;

    int n_tests = 0;
    int n_fail  = 0;

    clk_10k_monitor #(
        .CNT_W(CNT_W), .NOM_PERIOD(NOM), .TOL(TOL), .TIMEOUT(TIMEOUT), .LOCK_CNT(LOCK)
    ) dut (
        .clk_sys(clk_sys), .rst(rst), .en(en), .clk_in(clk_in),
        .period_out(period_out), .period_valid(period_valid), .period_ok(period_ok),
        .clk_lost(clk_lost), .clk_locked(clk_locked)
    );

    always #10 clk_sys = ~clk_sys;

    // Model: timestamps of registered rises; a period is simply the edge-count difference.
    typedef enum {M_OFF, M_WAIT, M_MEAS} mphase_t;
    mphase_t ph       = M_OFF;
    int      edge_n   = 0;
    int      t_ref    = 0;
    int      run      = 0;
    int      m_period = 0;
    bit      m_valid  = 0;
    bit      m_ok     = 0;
    bit      m_lost   = 0;
    bit      m_locked = 0;
    bit      started  = 0;
    bit      h0 = 0, h1 = 0, h2 = 0;

    always @(posedge clk_sys) begin
        bit rise_m;
        int p;
        edge_n++;
        rise_m  = h1 & ~h2;
        m_valid = 0;
        if (rst) begin
            started = 1;
            h0 = 0; h1 = 0; h2 = 0;
            ph = M_OFF; run = 0; m_period = 0; m_ok = 0; m_lost = 0; m_locked = 0;
        end else begin
            h2 = h1; h1 = h0; h0 = clk_in;
            if (!en) begin
                ph = M_OFF; run = 0; m_lost = 0; m_locked = 0;
            end else begin
                case (ph)
                    M_OFF: begin
                        ph = M_WAIT; t_ref = edge_n + 1;
                    end
                    M_WAIT: begin
                        if (rise_m) begin
                            m_lost = 0; ph = M_MEAS; t_ref = edge_n;
                        end else if (edge_n - t_ref == TIMEOUT) begin
                            m_lost = 1; m_locked = 0; run = 0; t_ref = edge_n + 1;
                        end
                    end
                    default: begin
                        if (rise_m) begin
                            p = edge_n - t_ref;
                            m_period = p; m_valid = 1;
                            m_ok = (p >= NOM - TOL) && (p <= NOM + TOL);
                            if (m_ok) begin
                                if (run < LOCK) run++;
                                m_locked = (run == LOCK);
                            end else begin
                                run = 0; m_locked = 0;
                            end
                            t_ref = edge_n;
                        end else if (edge_n - t_ref == TIMEOUT) begin
                            m_lost = 1; m_locked = 0; run = 0; ph = M_WAIT; t_ref = edge_n + 1;
                        end
                    end
                endcase
            end
        end
    end

    typedef struct {int period; bit ok; bit locked; int cyc;} vrec_t;
    vrec_t vq[$];
    int    ncyc     = 0;
    int    lost_cyc = -1;
    bit    lost_d   = 0;

    always @(negedge clk_sys) begin
        vrec_t r;
        ncyc++;
        if (started) begin
            n_tests++;
            if (period_out !== CNT_W'(m_period) || period_valid !== m_valid || period_ok !== m_ok ||
                clk_lost !== m_lost || clk_locked !== m_locked) begin
                n_fail++;
                $display("FAIL model cycle %0d: out=%0d vld=%b ok=%b lost=%b lk=%b, expected out=%0d vld=%b ok=%b lost=%b lk=%b",
                         ncyc, period_out, period_valid, period_ok, clk_lost, clk_locked,
                         m_period, m_valid, m_ok, m_lost, m_locked);
            end
        end
        if (period_valid === 1'b1) begin
            r.period = int'(period_out); r.ok = period_ok; r.locked = clk_locked; r.cyc = ncyc;
            vq.push_back(r);
        end
        if (clk_lost === 1'b1 && !lost_d) lost_cyc = ncyc;
        lost_d = (clk_lost === 1'b1);
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic check_valid(input int idx, input int per, input int ok, input int lk);
        if (vq.size() <= idx) begin
            n_tests++; n_fail++;
            $display("FAIL valid%0d_present: got %0d records, expected more than %0d", idx, vq.size(), idx);
        end else begin
            check($sformatf("valid%0d_period", idx), vq[idx].period, per);
            check($sformatf("valid%0d_ok", idx), int'(vq[idx].ok), ok);
            check($sformatf("valid%0d_locked", idx), int'(vq[idx].locked), lk);
        end
    endtask

    task automatic pulse(input int p);
        clk_in = 1'b1;
        tick(p / 2);
        clk_in = 1'b0;
        tick(p - p / 2);
    endtask

    initial begin
        int per[9];
        int okv[9];
        int lkv[9];
        per = '{5000, 5000, 5000, 5000, 5100, 4950, 5050, 5000, 5000};
        okv = '{1, 1, 1, 1, 0, 1, 1, 1, 1};
        lkv = '{0, 0, 0, 1, 0, 0, 0, 0, 1};

        tick(3);
        check("reset_period_out", int'(period_out), 0);
        check("reset_valid", int'(period_valid), 0);
        check("reset_ok", int'(period_ok), 0);
        check("reset_lost", int'(clk_lost), 0);
        check("reset_locked", int'(clk_locked), 0);
        rst = 1'b0; en = 1'b1;
        tick(5);

        // Nine intervals, then a tenth rise that closes the last one before clk_in stops.
        foreach (per[i]) pulse(per[i]);
        clk_in = 1'b1;
        tick(100);
        clk_in = 1'b0;
        for (int i = 0; i < 12000 && clk_lost !== 1'b1; i++) tick(1);
        tick(1);
        check("valid_count_lock", vq.size(), 9);
        for (int i = 0; i < 9; i++) check_valid(i, per[i], okv[i], lkv[i]);
        check("lost_asserted", int'(clk_lost), 1);
        check("locked_after_lost", int'(clk_locked), 0);
        if (vq.size() >= 9) check("lost_delay", lost_cyc - vq[8].cyc, 10000);

        clk_in = 1'b1;
        tick(10);
        check("lost_clears_on_rise", int'(clk_lost), 0);
        check("no_valid_on_resume", vq.size(), 9);
        tick(4949 / 2 - 10);
        clk_in = 1'b0;
        tick(4949 - 4949 / 2);
        pulse(5051);

        clk_in = 1'b1;
        tick(1000);
        check("valid_count_resume", vq.size(), 11);
        check_valid(9, 4949, 0, 0);
        check_valid(10, 5051, 0, 0);
        en = 1'b0;
        tick(100);
        check("locked_en_off", int'(clk_locked), 0);
        check("lost_en_off", int'(clk_lost), 0);
        en = 1'b1;
        clk_in = 1'b0;
        tick(900);
        pulse(5000);
        check("no_valid_after_en", vq.size(), 11);
        check("period_held_en", int'(period_out), 5051);

        clk_in = 1'b1;
        tick(1000);
        check("valid_count_en", vq.size(), 12);
        check_valid(11, 5000, 1, 0);
        clk_in = 1'b0;
        tick(500);
        rst = 1'b1;
        tick(1);
        check("rst_mid_period_out", int'(period_out), 0);
        check("rst_mid_valid", int'(period_valid), 0);
        check("rst_mid_ok", int'(period_ok), 0);
        check("rst_mid_lost", int'(clk_lost), 0);
        check("rst_mid_locked", int'(clk_locked), 0);
        rst = 1'b0;
        tick(100);
        pulse(5000);
        check("no_valid_first_rise_after_rst", vq.size(), 12);
        clk_in = 1'b1;
        tick(100);
        clk_in = 1'b0;
        tick(10);
        check("valid_count_rst", vq.size(), 13);
        check_valid(12, 5000, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
